// File: rtl/sky130_ef_io__gpiov2_bank_ctrl.sv
// Control bank for an array of gpiov2 pads: hold-protected static config writes,
// registered output/enable path and synchronised, deglitched input path with edge pulses.
module sky130_ef_io__gpiov2_bank_ctrl #(
    parameter int NPADS           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEGLITCH_CYCLES = 4,
    parameter int HOLD_DELAY      = 16,
    localparam int AW = (NPADS > 1) ? $clog2(NPADS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [AW-1:0]        CFG_ADDR,
    input  logic [7:0]           CFG_DATA,
    output logic                 CFG_ERR,
    output logic                 BUSY,
    input  logic [NPADS-1:0]     OUT_DATA,
    input  logic [NPADS-1:0]     OUT_EN,
    input  logic [NPADS-1:0]     PAD_IN,
    output logic [NPADS-1:0]     IN_FILT,
    output logic [NPADS-1:0]     IN_RISE,
    output logic [NPADS-1:0]     IN_FALL,
    output logic [NPADS-1:0]     PAD_OUT,
    output logic [NPADS-1:0]     PAD_OE_N,
    output logic [3*NPADS-1:0]   PAD_DM,
    output logic [NPADS-1:0]     PAD_INP_DIS,
    output logic [NPADS-1:0]     PAD_SLOW,
    output logic [NPADS-1:0]     PAD_VTRIP_SEL,
    output logic [NPADS-1:0]     PAD_IB_MODE_SEL,
    output logic [NPADS-1:0]     PAD_ANALOG_EN,
    output logic [NPADS-1:0]     PAD_HLD_H_N
);
    localparam int HW = $clog2(HOLD_DELAY + 1);
    localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
    localparam logic [AW:0]   NPADS_W   = (AW + 1)'(NPADS);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_DELAY - 1);
    localparam logic [DW-1:0] DEG_LAST  = DW'(DEGLITCH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_UPDATE, S_RELEASE} state_e;

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic          cfg_wr;

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = 1'b0;
        cfg_wr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CFG_VALID) begin
                    addr_d = CFG_ADDR;
                    data_d = CFG_DATA;
                    if ({1'b0, CFG_ADDR} >= NPADS_W) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = S_SETUP;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            S_SETUP: begin
                if (hold_cnt_q == '0) state_d = S_UPDATE;
                else                  hold_cnt_d = hold_cnt_q - 1'b1;
            end
            S_UPDATE: begin
                cfg_wr     = 1'b1;
                state_d    = S_RELEASE;
                hold_cnt_d = HOLD_LOAD;
            end
            S_RELEASE: begin
                if (hold_cnt_q == '0) state_d = S_IDLE;
                else                  hold_cnt_d = hold_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign CFG_READY = (state_q == S_IDLE);
    assign BUSY      = ~CFG_READY;
    assign CFG_ERR   = err_q;

    for (genvar gi = 0; gi < NPADS; gi++) begin : g_pad
        logic                   sel;
        logic                   differ;
        logic [7:0]             cfg_q;
        logic                   out_q, oe_n_q;
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          dg_cnt_q;
        logic                   filt_q, rise_q, fall_q;

        assign sel    = (addr_q == AW'(gi));
        assign differ = (sync_q[SYNC_STAGES-1] != filt_q);

        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                cfg_q    <= 8'h01;
                out_q    <= 1'b0;
                oe_n_q   <= 1'b1;
                sync_q   <= '0;
                dg_cnt_q <= '0;
                filt_q   <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                if (cfg_wr && sel) cfg_q <= data_q;
                // The pad under a hold sequence keeps the drive it had when the sequence began.
                if (!(BUSY && sel)) begin
                    out_q  <= OUT_DATA[gi];
                    oe_n_q <= ~OUT_EN[gi];
                end
                sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_IN[gi]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (cfg_q[3] || !differ) begin
                    dg_cnt_q <= '0;
                end else if (dg_cnt_q == DEG_LAST) begin
                    dg_cnt_q <= '0;
                    filt_q   <= ~filt_q;
                    rise_q   <= ~filt_q;
                    fall_q   <= filt_q;
                end else begin
                    dg_cnt_q <= dg_cnt_q + 1'b1;
                end
            end
        end

        assign PAD_OUT[gi]         = out_q;
        assign PAD_OE_N[gi]        = oe_n_q;
        assign PAD_DM[3*gi +: 3]   = cfg_q[2:0];
        assign PAD_INP_DIS[gi]     = cfg_q[3];
        assign PAD_SLOW[gi]        = cfg_q[4];
        assign PAD_VTRIP_SEL[gi]   = cfg_q[5];
        assign PAD_IB_MODE_SEL[gi] = cfg_q[6];
        assign PAD_ANALOG_EN[gi]   = cfg_q[7];
        assign PAD_HLD_H_N[gi]     = ~(BUSY && sel);
        assign IN_FILT[gi]         = filt_q;
        assign IN_RISE[gi]         = rise_q;
        assign IN_FALL[gi]         = fall_q;
    end

endmodule
